// File: rtl/sev_key_table.sv
// Per-ASID key store for the SEV XOR stage, zeroized by a scrub FSM after reset/flush; SEV_KEY_PARITY_EN adds per-entry parity.
// Lookup latency: exactly 1 cycle, response registered.
// Backpressure: response held until resp_ready_i; req_ready_o/prog_ready_o low while scrubbing.
module sev_key_table #(
  parameter int NUM_ASID = 16,
  parameter int ASID_W   = 4,
  parameter int KEY_W    = 64,
  parameter int TAG_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_valid_i,
  output logic              prog_ready_o,
  input  logic              prog_inval_i,
  input  logic [ASID_W-1:0] prog_asid_i,
  input  logic [KEY_W-1:0]  prog_key_i,
  output logic              prog_err_o,
  input  logic              flush_i,
  output logic              busy_o,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ASID_W-1:0] req_asid_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [KEY_W-1:0]  resp_key_o,
  output logic              resp_hit_o,
  output logic [TAG_W-1:0]  resp_tag_o,
  output logic              parity_err_o
);

  typedef enum logic {ST_SCRUB, ST_IDLE} state_t;

  typedef struct packed {
    logic             hit;
    logic [KEY_W-1:0] key;
    logic [TAG_W-1:0] tag;
  } resp_t;

  state_t              state_q, state_d;
  logic [ASID_W-1:0]   idx_q, idx_d;
  logic [KEY_W-1:0]    key_mem [NUM_ASID];
  logic [NUM_ASID-1:0] vld_q;
  logic                prog_fire, req_fire, scrub_wr, wr_en, wr_vld;
  logic [ASID_W-1:0]   wr_asid;
  logic [KEY_W-1:0]    wr_key, rd_key;
  logic                rd_vld, rd_bad;
  resp_t               lk, resp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_SCRUB;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_o       = 1'b0;
    req_ready_o  = 1'b0;
    prog_ready_o = 1'b0;
    case (state_q)
      ST_SCRUB: begin
        busy_o = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == ASID_W'(NUM_ASID - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      ST_IDLE: begin
        // A flush still lets a same-cycle lookup through, but blocks programming.
        req_ready_o  = !resp_valid_o || resp_ready_i;
        prog_ready_o = !flush_i;
        if (flush_i) begin
          state_d = ST_SCRUB;
          idx_d   = '0;
        end
      end
      default: state_d = ST_SCRUB;
    endcase
  end

  assign prog_fire = prog_valid_i && prog_ready_o;
  assign req_fire  = req_valid_i && req_ready_o;
  assign scrub_wr  = (state_q == ST_SCRUB);

  // Single write port shared by scrub and programming; ASID 0 is never stored.
  assign wr_en   = scrub_wr || (prog_fire && (prog_asid_i != '0));
  assign wr_asid = scrub_wr ? idx_q : prog_asid_i;
  assign wr_vld  = !scrub_wr && !prog_inval_i;
  assign wr_key  = wr_vld ? prog_key_i : '0;

  always_ff @(posedge clk_i) begin
    if (wr_en) key_mem[wr_asid] <= wr_key;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      vld_q <= '0;
    else if (wr_en) vld_q[wr_asid] <= wr_vld;
  end

  assign rd_key = key_mem[req_asid_i];
  assign rd_vld = vld_q[req_asid_i];

`ifdef SEV_KEY_PARITY_EN
  logic [NUM_ASID-1:0] par_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) par_q[wr_asid] <= ^wr_key;
  end

  assign rd_bad = (par_q[req_asid_i] != ^rd_key);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) parity_err_o <= 1'b0;
    else       parity_err_o <= req_fire && (req_asid_i != '0) && rd_vld && rd_bad;
  end
`else
  assign rd_bad       = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // Reads see pre-write contents, so a same-cycle program is invisible to this lookup.
  always_comb begin
    lk.tag = req_tag_i;
    lk.hit = 1'b0;
    lk.key = '0;
    if (req_asid_i == '0) begin
      lk.hit = 1'b1;
    end else if (rd_vld && !rd_bad) begin
      lk.hit = 1'b1;
      lk.key = rd_key;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_o <= 1'b0;
      resp_q       <= '0;
      prog_err_o   <= 1'b0;
    end else begin
      prog_err_o <= prog_fire && (prog_asid_i == '0);
      if (req_fire) begin
        resp_valid_o <= 1'b1;
        resp_q       <= lk;
      end else if (resp_ready_i) begin
        resp_valid_o <= 1'b0;
      end
    end
  end

  assign resp_key_o = resp_q.key;
  assign resp_hit_o = resp_q.hit;
  assign resp_tag_o = resp_q.tag;

endmodule

// File: doc/sev_key_table.md
Name: sev_key_table

Overview:
- Per-ASID key store feeding the SEV XOR encryption stage; its response key drives that stage's key_i.
- The hypervisor/PSP side programs or invalidates 64-bit keys per ASID.
- The memory pipeline issues tagged lookups and receives a registered key, with hit flag, one cycle later over valid/ready.
- Contains a scrub FSM that zeroizes all key storage after reset and on flush.

Parameters:
NUM_ASID, 16, number of key entries (power of two, >=2)
ASID_W, 4, ASID width, equals log2(NUM_ASID)
KEY_W, 64, key width
TAG_W, 8, opaque request tag width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
prog_valid_i  in  1  program/invalidate request
prog_ready_o  out  1  program accepted when valid&ready
prog_inval_i  in  1  1=invalidate entry, 0=write key
prog_asid_i  in  ASID_W  target ASID
prog_key_i  in  KEY_W  key to write
prog_err_o  out  1  one-cycle pulse: program to ASID 0 rejected
flush_i  in  1  request full scrub (level, sampled in IDLE)
busy_o  out  1  scrub in progress
req_valid_i  in  1  lookup request
req_ready_o  out  1  lookup accepted when valid&ready
req_asid_i  in  ASID_W  lookup ASID
req_tag_i  in  TAG_W  request tag
resp_valid_o  out  1  response valid
resp_ready_i  in  1  consumer ready
resp_key_o  out  KEY_W  key (0 on miss)
resp_hit_o  out  1  entry valid
resp_tag_o  out  TAG_W  echoed tag
parity_err_o  out  1  one-cycle pulse on parity mismatch (see Optional Feature)

Behaviour:
- Reset (async): state=SCRUB, scrub index=0, all valid bits=0, resp_valid_o=0, resp_key_o=0, resp_hit_o=0, resp_tag_o=0, prog_err_o=0, parity_err_o=0, busy_o=1.
- FSM states:
  - SCRUB: writes key=0, valid=0 to entry[idx] each cycle; idx increments. After entry NUM_ASID-1 is written, next state is IDLE. Takes exactly NUM_ASID cycles.
  - IDLE: if flush_i=1, go to SCRUB with idx=0. A flush in the same cycle as an accepted lookup: the lookup completes; the flush wins over a same-cycle program (prog_ready_o=0 that cycle).
- busy_o=1 in SCRUB. req_ready_o=0 and prog_ready_o=0 in SCRUB.
- prog_ready_o=1 in IDLE when flush_i=0.
- Program write sets key[asid]=prog_key_i, valid=1. Invalidate sets valid=0, key=0.
- Program to ASID 0 is accepted but discarded; prog_err_o pulses 1 cycle later.
- Lookup:
  - req_ready_o = (state==IDLE) && (!resp_valid_o || resp_ready_i).
  - On acceptance, the response registers load next cycle, so latency is exactly 1 cycle.
  - ASID 0 (host): hit=1, key=0.
  - Valid entry: hit=1, key=stored key.
  - Invalid entry: hit=0, key=0. A stale key is never exposed.
- Response hold: resp_valid_o stays high and all resp_* are stable until resp_ready_i=1. A valid&ready with no new accept clears resp_valid_o. Back-to-back accepts sustain 1 lookup/cycle.
- Same-cycle program and lookup of the same ASID: the lookup returns the pre-write value (read-before-write). The following lookup sees the new value.
- Reset mid-operation: in-flight response dropped, outputs go to reset values, scrub restarts.

Optional Feature:
- SEV_KEY_PARITY_EN defined:
  - Each entry stores an even-parity bit over key, computed on write; scrub writes parity of 0.
  - Lookup of a valid entry with mismatched parity returns hit=0, key=0, and pulses parity_err_o coincident with the first cycle resp_valid_o goes high for that response.
  - Parity is checked only on valid, non-zero ASIDs.
- Not defined: no parity storage; parity_err_o tied to 0.

Test Plan:
- Reset release -> busy_o=1 for exactly 16 cycles, req_ready_o=0 throughout; then busy_o=0, and a lookup of ASID 5 returns hit=0, key=0.
- Program ASID 3 key 0xDEADBEEF_CAFEF00D, then look up ASID 3 tag 0x2A -> resp next cycle: hit=1, key=0xDEADBEEF_CAFEF00D, tag=0x2A; invalidate ASID 3 then look it up -> hit=0, key=0.
- Lookups to ASIDs 1,2,3 on consecutive cycles with resp_ready_i=0 for 3 cycles -> first response held stable, req_ready_o=0; release -> responses delivered in order with correct tags, none lost or duplicated.
- Same-cycle program ASID 7 = 0x1111 (old 0x2222) and lookup ASID 7 -> response key 0x2222; the next lookup returns 0x1111.
- Program ASID 0 = 0xFFFF -> prog_err_o pulses once; lookup ASID 0 -> hit=1, key=0. Assert flush_i with 4 programmed entries -> 16 busy cycles, then all non-zero ASIDs miss.
- SEV_KEY_PARITY_EN: force a bit flip in stored key of ASID 4 -> lookup returns hit=0, key=0, parity_err_o=1 for one cycle; without the macro, parity_err_o stays 0.
